// File: rtl/apb_pkg.sv
// rtl/apb_pkg.sv - shared defaults and FSM state type for the two-requester APB master
package apb_pkg;
  localparam int A_WIDTH_DEF = 8;
  localparam int D_WIDTH_DEF = 8;
  localparam int TIMEOUT_DEF = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } state_t;
endpackage

// File: rtl/apb_rr_arb.sv
// rtl/apb_rr_arb.sv - two-way round-robin arbiter with per-requester mask
module apb_rr_arb (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic [1:0] mask,
  input  logic       update,
  output logic [1:0] grant,
  output logic       ptr
);
  logic [1:0] elig;

  assign elig = req & ~mask;

  always_comb begin
    grant = elig;
    if (elig == 2'b11) begin
      grant = ptr ? 2'b10 : 2'b01;
    end
  end

  // The pointer only moves when there was a real choice to make, so a forced
  // back-to-back hand-over does not disturb the fairness order.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= 1'b0;
    end else if (update && elig == 2'b11) begin
      ptr <= grant[0];
    end
  end
endmodule

// File: rtl/apb_arb_master.sv
// rtl/apb_arb_master.sv - APB master shared by two requesters, with wait-state timeout
module apb_arb_master
  import apb_pkg::*;
#(
  parameter int A_WIDTH = A_WIDTH_DEF,
  parameter int D_WIDTH = D_WIDTH_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic                 p_clk,
  input  logic                 p_rst,
  input  logic [1:0]           req,
  input  logic [1:0]           req_write,
  input  logic [2*A_WIDTH-1:0] req_addr,
  input  logic [2*D_WIDTH-1:0] req_wdata,
  output logic [1:0]           done,
  output logic                 err,
  output logic [D_WIDTH-1:0]   rsp_rdata,
  output logic                 p_sel,
  output logic                 p_enable,
  output logic                 p_write,
  output logic [A_WIDTH-1:0]   p_addr,
  output logic [D_WIDTH-1:0]   wr_data,
  input  logic [D_WIDTH-1:0]   rd_data,
  input  logic                 p_ready
);
  localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

  state_t     state, state_next;
  logic [1:0] grant, grant_q, mask;
  logic       fire, complete, abort;
  logic [7:0] cnt;
  logic       unused_rr_ptr;

  // The finishing requester is masked at its completing edge and while done is high.
  assign mask = done | ((state == ACCESS) ? grant_q : 2'b00);

  apb_rr_arb u_arb (
    .clk    (p_clk),
    .rst    (p_rst),
    .req    (req),
    .mask   (mask),
    .update (fire),
    .grant  (grant),
    .ptr    (unused_rr_ptr)
  );

  always_ff @(posedge p_clk) begin
    if (p_rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    fire       = 1'b0;
    complete   = 1'b0;
    abort      = 1'b0;
    case (state)
      IDLE: begin
        if (|grant) begin
          state_next = SETUP;
          fire       = 1'b1;
        end
      end
      SETUP: state_next = ACCESS;
      ACCESS: begin
        if (p_ready) begin
          complete = 1'b1;
          if (|grant) begin
            state_next = SETUP;
            fire       = 1'b1;
          end else begin
            state_next = IDLE;
          end
        end else if (cnt == TIMEOUT_CNT) begin
          abort      = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge p_clk) begin
    if (p_rst) begin
      p_sel     <= 1'b0;
      p_enable  <= 1'b0;
      p_write   <= 1'b0;
      p_addr    <= '0;
      wr_data   <= '0;
      done      <= 2'b00;
      err       <= 1'b0;
      rsp_rdata <= '0;
      grant_q   <= 2'b00;
      cnt       <= 8'd0;
    end else begin
      p_sel    <= (state_next != IDLE);
      p_enable <= (state_next == ACCESS);
      done     <= (complete || abort) ? grant_q : 2'b00;
      err      <= abort;
      if (fire) begin
        grant_q <= grant;
        p_write <= grant[1] ? req_write[1] : req_write[0];
        p_addr  <= grant[1] ? req_addr[2*A_WIDTH-1:A_WIDTH] : req_addr[A_WIDTH-1:0];
        wr_data <= grant[1] ? req_wdata[2*D_WIDTH-1:D_WIDTH] : req_wdata[D_WIDTH-1:0];
      end
      if (complete && !p_write) begin
        rsp_rdata <= rd_data;
      end
      // cnt holds the index of the current ACCESS cycle, starting at 1.
      if (state == SETUP) begin
        cnt <= 8'd1;
      end else if (state == ACCESS && state_next == ACCESS) begin
        cnt <= cnt + 8'd1;
      end else begin
        cnt <= 8'd0;
      end
    end
  end
endmodule

// File: tb/tb_apb_arb_master.sv
// tb/tb_apb_arb_master.sv - scoreboard bench for apb_arb_master
module tb_apb_arb_master;
  logic        p_clk;
  logic        p_rst;
  logic [1:0]  req;
  logic [1:0]  req_write;
  logic [15:0] req_addr;
  logic [15:0] req_wdata;
  logic [1:0]  done;
  logic        err;
  logic [7:0]  rsp_rdata;
  logic        p_sel;
  logic        p_enable;
  logic        p_write;
  logic [7:0]  p_addr;
  logic [7:0]  wr_data;
  logic [7:0]  rd_data;
  logic        p_ready;

  apb_arb_master dut (
    .p_clk     (p_clk),
    .p_rst     (p_rst),
    .req       (req),
    .req_write (req_write),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .done      (done),
    .err       (err),
    .rsp_rdata (rsp_rdata),
    .p_sel     (p_sel),
    .p_enable  (p_enable),
    .p_write   (p_write),
    .p_addr    (p_addr),
    .wr_data   (wr_data),
    .rd_data   (rd_data),
    .p_ready   (p_ready)
  );

  initial begin
    p_clk = 1'b0;
    forever #5 p_clk = ~p_clk;
  end

  typedef struct {
    int       id;
    bit       wr;
    bit [7:0] addr;
    bit [7:0] wdata;
    bit [7:0] rdata;
    bit       er;
    int       nacc;
    bit       b2b;
  } txn_t;

  txn_t        exp_q[$];
  int          n_checks = 0;
  int          n_errors = 0;
  int          acc = 0;
  int          wait_states = 0;
  logic [16:0] lat = '0;
  logic [1:0]  hold = 2'b00;
  logic [1:0]  pend = 2'b00;
  logic [7:0]  cur_rdata = 8'h00;
  logic [7:0]  model_rdata = 8'h00;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic issue(input int id, input bit wr, input bit [7:0] addr, input bit [7:0] wdata,
                       input bit [7:0] rdata, input bit er, input int nacc, input bit b2b);
    txn_t t;
    t.id = id; t.wr = wr; t.addr = addr; t.wdata = wdata;
    t.rdata = rdata; t.er = er; t.nacc = nacc; t.b2b = b2b;
    exp_q.push_back(t);
    req_write[id]       = wr;
    req_addr[id*8 +: 8]  = addr;
    req_wdata[id*8 +: 8] = wdata;
    req[id]             = 1'b1;
  endtask

  task automatic step();
    txn_t t;
    @(negedge p_clk);
    if (done != 2'b00) begin
      if (exp_q.size() == 0) begin
        check("unexpected_done", {30'd0, done}, 32'd0);
      end else begin
        t = exp_q.pop_front();
        check("done_id", {30'd0, done}, 32'd1 << t.id);
        check("err", {31'd0, err}, {31'd0, t.er});
        check("access_cycles", acc, t.nacc);
        check("b2b_psel", {31'd0, p_sel}, {31'd0, t.b2b});
        if (!t.er && !t.wr) model_rdata = t.rdata;
        check("rsp_rdata", {24'd0, rsp_rdata}, {24'd0, model_rdata});
      end
    end
    if (p_sel && !p_enable) begin
      acc = 0;
      if (exp_q.size() == 0) begin
        check("unexpected_setup", 32'd1, 32'd0);
      end else begin
        check("setup_addr", {24'd0, p_addr}, {24'd0, exp_q[0].addr});
        check("setup_write", {31'd0, p_write}, {31'd0, exp_q[0].wr});
        check("setup_wdata", {24'd0, wr_data}, {24'd0, exp_q[0].wdata});
        lat = {p_write, p_addr, wr_data};
      end
    end else if (p_sel && p_enable) begin
      acc++;
      check("access_stable", {15'd0, p_write, p_addr, wr_data}, {15'd0, lat});
    end
    p_ready = (p_sel && p_enable) ? (acc > wait_states) : 1'b1;
    rd_data = cur_rdata;
    for (int i = 0; i < 2; i++) begin
      if (pend[i]) begin
        req[i]  = 1'b0;
        pend[i] = 1'b0;
      end else if (done[i]) begin
        if (hold[i]) pend[i] = 1'b1;
        else req[i] = 1'b0;
      end
    end
  endtask

  task automatic run(input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      step();
      n++;
    end
    if (exp_q.size() != 0) begin
      check("cycle_budget", exp_q.size(), 0);
      exp_q.delete();
    end
    repeat (4) step();
  endtask

  task automatic do_reset();
    p_rst = 1'b1;
    req   = 2'b00;
    pend  = 2'b00;
    repeat (2) @(negedge p_clk);
    p_rst = 1'b0;
    model_rdata = 8'h00;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_psel"}, {31'd0, p_sel}, 32'd0);
    check({tag, "_penable"}, {31'd0, p_enable}, 32'd0);
    check({tag, "_pwrite"}, {31'd0, p_write}, 32'd0);
    check({tag, "_paddr"}, {24'd0, p_addr}, 32'd0);
    check({tag, "_wrdata"}, {24'd0, wr_data}, 32'd0);
    check({tag, "_done"}, {30'd0, done}, 32'd0);
    check({tag, "_err"}, {31'd0, err}, 32'd0);
    check({tag, "_rsp"}, {24'd0, rsp_rdata}, 32'd0);
  endtask

  initial begin
    p_rst = 1'b1; req = 2'b00; req_write = 2'b00;
    req_addr = '0; req_wdata = '0; rd_data = '0; p_ready = 1'b1;
    do_reset();
    check_reset_outputs("reset");

    // single write, ready in the first ACCESS cycle, req held one cycle past done
    wait_states = 0; hold = 2'b01;
    issue(0, 1'b1, 8'h45, 8'hA5, 8'h00, 1'b0, 1, 1'b0);
    run(50);
    hold = 2'b00;

    // read with three wait states
    wait_states = 3; cur_rdata = 8'h12;
    issue(1, 1'b0, 8'h65, 8'h3C, 8'h12, 1'b0, 4, 1'b0);
    run(50);

    // ready on the last allowed ACCESS cycle is still a normal completion
    wait_states = 15; cur_rdata = 8'h5A;
    issue(0, 1'b0, 8'h71, 8'h00, 8'h5A, 1'b0, 16, 1'b0);
    run(60);

    // slave never ready: abort with err, read data untouched
    wait_states = 1000; cur_rdata = 8'hC3;
    issue(1, 1'b0, 8'h0F, 8'h99, 8'hC3, 1'b1, 16, 1'b0);
    run(60);

    // write after timeout keeps the last read data
    wait_states = 1;
    issue(1, 1'b1, 8'h20, 8'h7E, 8'h00, 1'b0, 2, 1'b0);
    run(50);

    // reset during a wait state
    wait_states = 1000;
    issue(0, 1'b0, 8'h33, 8'h44, 8'h00, 1'b0, 1, 1'b0);
    repeat (5) step();
    p_rst = 1'b1; req = 2'b00; exp_q.delete();
    @(negedge p_clk);
    p_rst = 1'b0; model_rdata = 8'h00;
    check_reset_outputs("midreset");
    repeat (3) step();

    // contention from reset: 0 then 1 back-to-back, then 1 then 0
    wait_states = 0;
    issue(0, 1'b1, 8'hA0, 8'h01, 8'h00, 1'b0, 1, 1'b1);
    issue(1, 1'b1, 8'hB0, 8'h02, 8'h00, 1'b0, 1, 1'b0);
    run(50);
    issue(1, 1'b1, 8'hB1, 8'h03, 8'h00, 1'b0, 1, 1'b1);
    issue(0, 1'b1, 8'hA1, 8'h04, 8'h00, 1'b0, 1, 1'b0);
    run(50);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/apb_arb_master.md
APB_ARB_MASTER -- requirements
Module: apb_arb_master

Interface
REQ-001 SHALL have parameters, one per line:
- A_WIDTH, default 8, address width.
- D_WIDTH, default 8, data width.
- TIMEOUT, default 16, maximum ACCESS cycles allowed before abort (legal range 2..255).
REQ-002 SHALL have ports, one per line:
- p_clk  in  1  clock.
- p_rst  in  1  reset.
- req  in  2  per-requester transfer request, level, held until done.
- req_write  in  2  per-requester direction, 1=write.
- req_addr  in  2xA_WIDTH  per-requester address.
- req_wdata  in  2xD_WIDTH  per-requester write data.
- done  out  2  one-cycle completion pulse to the granted requester.
- err  out  1  valid with done; 1 means the transfer timed out.
- rsp_rdata  out  D_WIDTH  read data of the last completed read.
- p_sel, p_enable, p_write  out  1 each  APB controls.
- p_addr  out  A_WIDTH  APB address.
- wr_data  out  D_WIDTH  APB write data.
- rd_data  in  D_WIDTH  APB read data.
- p_ready  in  1  APB slave ready.
REQ-003 SHALL use one clock, p_clk; reset p_rst is synchronous and active-high.

Function
REQ-004 SHALL implement the FSM IDLE -> SETUP -> ACCESS, with every APB output registered.
REQ-005 IDLE: if any eligible req is high at an edge, SHALL grant one requester, latch its write/addr/wdata, and enter SETUP; otherwise SHALL stay in IDLE.
REQ-006 SETUP: p_sel=1, p_enable=0; SHALL go to ACCESS unconditionally after 1 cycle; p_ready is ignored.
REQ-007 ACCESS: p_sel=1, p_enable=1; p_ready SHALL be sampled only in this state.
REQ-008 p_addr, p_write and wr_data SHALL stay constant from SETUP entry until ACCESS exit.
REQ-009 On ACCESS with p_ready=1, the next cycle SHALL have done[grant]=1 and err=0; for a read, rsp_rdata SHALL capture rd_data at that edge.
REQ-010 rsp_rdata SHALL hold its value across writes, timeouts and idle cycles.
REQ-011 Back-to-back: at ACCESS completion, if the other requester's req is high, the FSM SHALL go directly to SETUP for that requester; otherwise it SHALL go to IDLE.
REQ-012 Arbitration SHALL be 2-way round-robin: on simultaneous requests, the requester not granted last wins; after reset requester 0 has priority.
REQ-013 A requester SHALL be ineligible at the completing edge and in any cycle where its done=1, so a held req is not re-granted.
REQ-014 Timeout: an 8-bit counter SHALL count ACCESS cycles. If p_ready=0 on the TIMEOUT-th ACCESS cycle, the FSM SHALL abort to IDLE and the next cycle SHALL have done[grant]=1 and err=1; rsp_rdata is unchanged.
REQ-015 p_ready=1 on the TIMEOUT-th cycle SHALL count as normal completion (err=0).
REQ-016 In IDLE: p_sel=0, p_enable=0; p_addr, p_write and wr_data SHALL hold their last values.
REQ-017 req changes during SETUP/ACCESS SHALL NOT affect the transfer in flight.

Reset
REQ-018 p_rst=1 at an edge SHALL force IDLE, including mid-transfer, with no done pulse for the aborted transfer.
REQ-019 Reset values: p_sel=0, p_enable=0, p_write=0, p_addr=0, wr_data=0, done=0, err=0, rsp_rdata=0, timeout counter=0, round-robin pointer favouring requester 0.

Structure
REQ-020 Package apb_pkg SHALL hold the A_WIDTH/D_WIDTH defaults, the state enum (IDLE, SETUP, ACCESS) and the TIMEOUT default.
REQ-021 Round-robin selection SHALL be in sub-module apb_rr_arb (inputs: req, mask, update; outputs: one-hot grant, pointer register).

Verification
REQ-022 Single write: req[0]=1, write, addr 0x45, wdata 0xA5, slave ready in first ACCESS -> SETUP 1 cycle, ACCESS 1 cycle, done[0] pulse, err=0.
REQ-023 Read with wait states: req[1]=1, addr 0x65, p_ready after 3 ACCESS cycles, rd_data=0x12 -> addr/ctrl stable throughout, rsp_rdata=0x12, done[1].
REQ-024 Contention: req=2'b11 from reset -> grants 0 then 1 back-to-back (no IDLE cycle between); repeat -> order 1 then 0.
REQ-025 Timeout: p_ready held 0, TIMEOUT=16 -> exactly 16 ACCESS cycles, then done with err=1, FSM in IDLE.
REQ-026 Reset mid-ACCESS: p_rst=1 during a wait state -> next cycle p_sel=0, p_enable=0, done=0, all outputs at reset values.
REQ-027 Held req: requester keeps req=1 for one cycle after done -> no duplicate transfer issued.
